// File: rtl/word_gen_reader_pkg.sv
// -----------------------------------------------------------------------------
// word_gen_reader_pkg
// Shared definitions for the word generator storage reader.
//
// Contents:
//   `MSB(x)    index of the most significant set bit of x; sizes the storage
//              read address.
//   state_e    reader FSM states and their encodings.
//   HDR_WORDS  number of header words sent ahead of the key words.
//   HDR_*      header word 0 field layout ({pkt_id, word_id}).
//   hdr0_word  builds header word 0 from its two id fields.
// -----------------------------------------------------------------------------
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package word_gen_reader_pkg;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_HDR0_ENC    = 3'd1;
  localparam logic [2:0] ST_HDR1_ENC    = 3'd2;
  localparam logic [2:0] ST_FETCH_ENC   = 3'd3;
  localparam logic [2:0] ST_WRITE_ENC   = 3'd4;
  localparam logic [2:0] ST_RELEASE_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_HDR0    = ST_HDR0_ENC,
    ST_HDR1    = ST_HDR1_ENC,
    ST_FETCH   = ST_FETCH_ENC,
    ST_WRITE   = ST_WRITE_ENC,
    ST_RELEASE = ST_RELEASE_ENC
  } state_e;

  localparam int HDR_WORDS    = 2;
  localparam int HDR_FIELD_W  = 16;
  localparam int HDR_PKT_LSB  = 16;
  localparam int HDR_WORD_LSB = 0;

  // Header word 0: packet id in the upper half, source word id in the lower.
  function automatic logic [31:0] hdr0_word(input logic [15:0] pkt_id,
                                            input logic [15:0] word_id);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[HDR_PKT_LSB +: HDR_FIELD_W]  = pkt_id;
    w[HDR_WORD_LSB +: HDR_FIELD_W] = word_id;
    return w;
  endfunction

endpackage

// File: rtl/word_gen_reader_if.sv
// -----------------------------------------------------------------------------
// word_gen_reader_if
// Output stream from the reader to the hash-core input FIFO.
//
// Signals:
//   dout         32-bit word
//   out_wr_en    dout is written this cycle
//   out_full     FIFO cannot accept a word
//   out_last     dout is the last word of the candidate
//   out_gen_end  candidate is the gen_end dummy
// Modports: master = reader side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface word_gen_reader_if;
  logic [31:0] dout;
  logic        out_wr_en;
  logic        out_full;
  logic        out_last;
  logic        out_gen_end;

  modport master (
    output dout, out_wr_en, out_last, out_gen_end,
    input  out_full
  );

  modport slave (
    input  dout, out_wr_en, out_last, out_gen_end,
    output out_full
  );
endinterface

// File: rtl/word_gen_reader_packer.sv
// -----------------------------------------------------------------------------
// word_gen_reader_packer
// Little-endian 4-byte pack register: byte din goes to lane `lane` when en.
// clr empties the register (and the zero-latch) at the start of a candidate.
//
// Optional feature (macro WORD_GEN_READER_NULL_TERM_EN): once a 0x00 byte has
// been packed, every later byte of the candidate is packed as 0x00. Without
// the macro bytes pass through verbatim.
//
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   clr          synchronous clear for a new candidate
//   en           write din into lane
//   lane         byte lane 0..3
//   din          storage byte
//   pack         packed 32-bit word
// -----------------------------------------------------------------------------
module word_gen_reader_packer
  import word_gen_reader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        en,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] pack
);

  logic [31:0] pack_r;
  logic [7:0]  byte_s;

`ifdef WORD_GEN_READER_NULL_TERM_EN
  logic        zero_r;

  // Byte actually stored: forced to zero after the terminator was seen.
  always_comb begin
    byte_s = din;
    if (zero_r) begin
      byte_s = 8'h00;
    end else begin
      byte_s = din;
    end
  end

  // Zero-latch: remembers that a 0x00 byte has already been packed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      zero_r <= 1'b0;
    end else if (clr) begin
      zero_r <= 1'b0;
    end else if (en && (din == 8'h00)) begin
      zero_r <= 1'b1;
    end
  end
`else
  // Bytes pass through unchanged.
  always_comb begin
    byte_s = din;
  end
`endif

  // Pack register: one byte lane written per enabled cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pack_r <= 32'h0000_0000;
    end else if (clr) begin
      pack_r <= 32'h0000_0000;
    end else if (en) begin
      pack_r[{lane, 3'b000} +: 8] <= byte_s;
    end
  end

  assign pack = pack_r;

endmodule

// File: rtl/word_gen_reader.sv
// -----------------------------------------------------------------------------
// word_gen_reader
// Reads a WORD_MAX_LEN-byte candidate from the word generator's storage,
// packs it into little-endian 32-bit words and streams
//   {pkt_id, word_id}, gen_id, key word 0 .. key word NW-1
// to the hash-core FIFO, then pulses set_empty to release the storage slot.
// A gen_end candidate sends only the two header words and reads no key bytes.
//
// Optional feature: WORD_GEN_READER_NULL_TERM_EN (see word_gen_reader_packer).
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   din              storage byte, combinational from rd_addr
//   rd_addr          storage read address
//   set_empty        one-cycle pulse: candidate consumed
//   empty            storage holds no candidate (sampled only in IDLE)
//   pkt_id_in, word_id_in, gen_id_in, gen_end_in   candidate attributes
//   out_if           output stream (master modport)
// -----------------------------------------------------------------------------
module word_gen_reader
  import word_gen_reader_pkg::*;
#(
  parameter  int WORD_MAX_LEN = 72,
  localparam int AW           = `MSB(WORD_MAX_LEN - 1) + 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [7:0]             din,
  output logic [AW-1:0]          rd_addr,
  output logic                   set_empty,
  input  logic                   empty,
  input  logic [15:0]            pkt_id_in,
  input  logic [15:0]            word_id_in,
  input  logic [31:0]            gen_id_in,
  input  logic                   gen_end_in,
  word_gen_reader_if.master      out_if
);

  localparam int NW         = WORD_MAX_LEN / 4;
  localparam int CAND_WORDS = HDR_WORDS + NW;
  localparam int CNT_W      = $clog2(CAND_WORDS + 1);

  state_e            state_r, state_s;
  logic [AW-1:0]     rd_addr_r;
  logic [CNT_W-1:0]  word_cnt_r;
  logic [15:0]       pkt_id_r, word_id_r;
  logic [31:0]       gen_id_r;
  logic              gen_end_r;

  logic [31:0]       pack_s;
  logic [31:0]       dout_s;
  logic              wr_s, last_s, gen_end_s, set_empty_s, fetch_s, clr_s;
  logic              last_word_s;

  // Words already emitted count the header too, so the last key word is the
  // one emitted when CAND_WORDS-1 words have gone out.
  assign last_word_s = (word_cnt_r == CNT_W'(CAND_WORDS - 1));

  // Next-state and stream outputs; all outputs drop to 0 outside emitting states.
  always_comb begin
    state_s     = state_r;
    dout_s      = 32'h0000_0000;
    wr_s        = 1'b0;
    last_s      = 1'b0;
    gen_end_s   = 1'b0;
    set_empty_s = 1'b0;
    fetch_s     = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (!empty) begin
          state_s = ST_HDR0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR0: begin
        dout_s    = hdr0_word(pkt_id_r, word_id_r);
        gen_end_s = gen_end_r;
        wr_s      = !out_if.out_full;
        if (!out_if.out_full) begin
          state_s = ST_HDR1;
        end else begin
          state_s = ST_HDR0;
        end
      end
      ST_HDR1: begin
        dout_s    = gen_id_r;
        last_s    = gen_end_r;
        gen_end_s = gen_end_r;
        wr_s      = !out_if.out_full;
        if (out_if.out_full) begin
          state_s = ST_HDR1;
        end else if (gen_end_r) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch_s = 1'b1;
        // Each word starts at lane 0, so lane 3 is the fourth byte.
        if (rd_addr_r[1:0] == 2'b11) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_WRITE: begin
        dout_s    = pack_s;
        last_s    = last_word_s;
        gen_end_s = gen_end_r;
        wr_s      = !out_if.out_full;
        if (out_if.out_full) begin
          state_s = ST_WRITE;
        end else if (last_word_s) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_RELEASE: begin
        set_empty_s = 1'b1;
        state_s     = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Candidate attributes, captured when a candidate is accepted in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pkt_id_r  <= 16'h0000;
      word_id_r <= 16'h0000;
      gen_id_r  <= 32'h0000_0000;
      gen_end_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && !empty) begin
      pkt_id_r  <= pkt_id_in;
      word_id_r <= word_id_in;
      gen_id_r  <= gen_id_in;
      gen_end_r <= gen_end_in;
    end
  end

  // Storage read address: restarts per candidate, advances per fetched byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_addr_r <= '0;
    end else if ((state_r == ST_IDLE) && !empty) begin
      rd_addr_r <= '0;
    end else if (fetch_s) begin
      if (rd_addr_r == AW'(WORD_MAX_LEN - 1)) begin
        rd_addr_r <= '0;
      end else begin
        rd_addr_r <= rd_addr_r + AW'(1);
      end
    end
  end

  // Emitted-word counter for the current candidate.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_cnt_r <= '0;
    end else if (clr_s) begin
      word_cnt_r <= '0;
    end else if (wr_s) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end
  end

  word_gen_reader_packer u_packer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (clr_s),
    .en    (fetch_s),
    .lane  (rd_addr_r[1:0]),
    .din   (din),
    .pack  (pack_s)
  );

  assign rd_addr            = rd_addr_r;
  assign set_empty          = set_empty_s;
  assign out_if.dout        = dout_s;
  assign out_if.out_wr_en   = wr_s;
  assign out_if.out_last    = last_s;
  assign out_if.out_gen_end = gen_end_s;

endmodule

// File: tb/tb_word_gen_reader.sv
// -----------------------------------------------------------------------------
// tb_word_gen_reader
// Drives word_gen_reader (WORD_MAX_LEN=8) from a byte-array storage model and
// checks the output stream against expected words built from the candidate
// bytes and ids. Covers reset state, plain / gen_end / stalled / reset-aborted
// / null-terminated / back-to-back candidates and a randomized run.
// -----------------------------------------------------------------------------
module tb_word_gen_reader;

  localparam int WML = 8;
  localparam int NW  = WML / 4;
  localparam int AW  = $clog2(WML);

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [7:0]    din;
  logic [AW-1:0] rd_addr;
  logic          set_empty;
  logic          empty;
  logic [15:0]   pkt_id_in;
  logic [15:0]   word_id_in;
  logic [31:0]   gen_id_in;
  logic          gen_end_in;

  logic [7:0]    mem [WML];

  word_gen_reader_if ifc ();

  always #5 CLK = ~CLK;

  assign din = mem[rd_addr];

  word_gen_reader #(.WORD_MAX_LEN(WML)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .din        (din),
    .rd_addr    (rd_addr),
    .set_empty  (set_empty),
    .empty      (empty),
    .pkt_id_in  (pkt_id_in),
    .word_id_in (word_id_in),
    .gen_id_in  (gen_id_in),
    .gen_end_in (gen_end_in),
    .out_if     (ifc)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          last_rel = -100;
  logic [31:0] exp_w [$];
  bit          exp_l [$];
  bit          exp_ge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Load a candidate into the storage model; byte i is bytes[8*i +: 8].
  task automatic load(input logic [15:0] p, input logic [15:0] w,
                      input logic [31:0] g, input bit ge, input logic [63:0] bytes);
    pkt_id_in  = p;
    word_id_in = w;
    gen_id_in  = g;
    gen_end_in = ge;
    for (int i = 0; i < WML; i++) mem[i] = bytes[8*i +: 8];
  endtask

  // Reference: expected word list for the loaded candidate.
  task automatic build_exp();
    logic [31:0] w;
    logic [7:0]  b;
`ifdef WORD_GEN_READER_NULL_TERM_EN
    bit          zseen;
    zseen = 1'b0;
`endif
    exp_w.delete();
    exp_l.delete();
    exp_ge = gen_end_in;
    exp_w.push_back({pkt_id_in, word_id_in}); exp_l.push_back(1'b0);
    exp_w.push_back(gen_id_in);               exp_l.push_back(gen_end_in);
    if (!gen_end_in) begin
      for (int k = 0; k < NW; k++) begin
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
          b = mem[4*k + j];
`ifdef WORD_GEN_READER_NULL_TERM_EN
          if (zseen) b = 8'h00;
          if (b == 8'h00) zseen = 1'b1;
`endif
          w = w | (32'(b) << (8 * j));
        end
        exp_w.push_back(w);
        exp_l.push_back(k == NW - 1);
      end
    end
  endtask

  // Offer the loaded candidate and check the stream until set_empty.
  // stall: 0 none, >0 random out_full percentage, <0 hold out_full for the
  // 3 cycles where key word 1 is presented. chain: leave empty low after release.
  task automatic run_cand(input int stall, input bit chain);
    int idx   = 0;
    int first = -1;
    int guard = 0;
    int w2    = -1;
    int k;
    bit done  = 1'b0;
    empty = 1'b0;
    while (!done && guard < 1000) begin
      @(negedge CLK);
      if (stall > 0) begin
        ifc.out_full = ($urandom_range(0, 99) < stall);
      end else if (stall < 0) begin
        k = cyc - w2;
        ifc.out_full = (idx == 3 && w2 >= 0 && k >= 5 && k <= 7);
      end else begin
        ifc.out_full = 1'b0;
      end
      #1;
      guard++;
      if (stall < 0 && ifc.out_full && exp_w.size() > 3) begin
        chk("stall_wr_en", 32'(ifc.out_wr_en), 32'd0);
        chk("stall_dout", ifc.dout, exp_w[3]);
        chk("stall_last", 32'(ifc.out_last), 32'(exp_l[3]));
      end
      if (ifc.out_wr_en) begin
        if (first < 0) begin
          first = cyc;
          chk("hdr_gap", 32'(cyc - last_rel >= 2), 32'd1);
        end
        chk("word_count_ok", 32'(idx < exp_w.size()), 32'd1);
        if (idx < exp_w.size()) begin
          chk($sformatf("dout[%0d]", idx), ifc.dout, exp_w[idx]);
          chk($sformatf("last[%0d]", idx), 32'(ifc.out_last), 32'(exp_l[idx]));
          chk($sformatf("gen_end[%0d]", idx), 32'(ifc.out_gen_end), 32'(exp_ge));
        end
        if (idx == 2) w2 = cyc;
        idx++;
      end
      if (exp_ge) chk("rd_addr_hold", 32'(rd_addr), 32'd0);
      if (set_empty) begin
        done     = 1'b1;
        last_rel = cyc;
        chk("words_at_release", idx, exp_w.size());
        if (stall == 0)
          chk("cand_cycles", cyc - first, exp_ge ? 2 : 2 + 5 * NW);
        if (stall < 0)
          chk("cand_cycles_stall", cyc - first, 2 + 5 * NW + 3);
        if (!chain) empty = 1'b1;
      end
    end
    chk("release_seen", 32'(done), 32'd1);
    if (!chain) begin
      repeat (3) begin
        @(negedge CLK);
        ifc.out_full = 1'b0;
        #1;
        chk("post_set_empty", 32'(set_empty), 32'd0);
        chk("post_wr_en", 32'(ifc.out_wr_en), 32'd0);
      end
    end
  endtask

  initial begin
    int nwr;
    logic [63:0] rb;
    RST_N        = 1'b0;
    empty        = 1'b1;
    ifc.out_full = 1'b0;
    load(16'h0, 16'h0, 32'h0, 1'b0, 64'h0);
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_dout", ifc.dout, 32'h0);
    chk("rst_wr_en", 32'(ifc.out_wr_en), 32'd0);
    chk("rst_last", 32'(ifc.out_last), 32'd0);
    chk("rst_gen_end", 32'(ifc.out_gen_end), 32'd0);
    chk("rst_set_empty", 32'(set_empty), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("idle_wr_en", 32'(ifc.out_wr_en), 32'd0);

    // 1: plain candidate
    load(16'h0012, 16'h0034, 32'd5, 1'b0, 64'h0807060504030201);
    build_exp();
    run_cand(0, 1'b0);

    // 2: gen_end dummy
    load(16'h0abc, 16'h0def, 32'd77, 1'b1, 64'h1122334455667788);
    build_exp();
    run_cand(0, 1'b0);

    // 3: out_full held while key word 1 is presented
    load(16'h0012, 16'h0034, 32'd5, 1'b0, 64'h0807060504030201);
    build_exp();
    run_cand(-1, 1'b0);

    // 4: reset in the middle of FETCH, candidate stays available
    load(16'h0055, 16'h0066, 32'h1234_5678, 1'b0, 64'h8877665544332211);
    build_exp();
    empty = 1'b0;
    nwr   = 0;
    for (int g = 0; g < 40 && nwr < 2; g++) begin
      @(negedge CLK);
      ifc.out_full = 1'b0;
      #1;
      chk("no_release_pre_reset", 32'(set_empty), 32'd0);
      if (ifc.out_wr_en) nwr++;
    end
    chk("pre_reset_hdr_words", nwr, 2);
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(ifc.out_wr_en), 32'd0);
    chk("midrst_set_empty", 32'(set_empty), 32'd0);
    chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    run_cand(0, 1'b0);

    // 5: embedded 0x00 byte
    load(16'h0001, 16'h0002, 32'd3, 1'b0, 64'h4746454443004241);
    build_exp();
    run_cand(0, 1'b0);

    // 6: two back-to-back candidates
    load(16'h0101, 16'h0202, 32'd9, 1'b0, 64'hf1e2d3c4b5a69788);
    build_exp();
    run_cand(0, 1'b1);
    load(16'h0303, 16'h0404, 32'd10, 1'b0, 64'h0f1e2d3c4b5a6978);
    build_exp();
    run_cand(0, 1'b0);

    // Randomized candidates with random back-pressure and chaining
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < WML; j++)
        rb[8*j +: 8] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      load(16'($urandom), 16'($urandom), $urandom, ($urandom_range(0, 5) == 0), rb);
      build_exp();
      run_cand(25, (i < 15) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
